spike_rate_decoder: RTL and testbench

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

---
 rtl/spike_rate_decoder.sv | 136 +++++++++++++
 tb/tb_spike_rate_decoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_decoder.sv
// Spike rate / inter-spike-interval decoder: counts rising edges of spike_in over a
// fixed window, tracks the last interval, and hands the result off with a valid/ready pair.
module spike_rate_decoder #(
  parameter int WINDOW = 1000,
  parameter int RATE_W = 8,
  parameter int ISI_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              spike_in,
  output logic [RATE_W-1:0] rate_out,
  output logic [ISI_W-1:0]  isi_out,
  output logic              overflow,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [RATE_W-1:0] CNT_MAX  = '1;
  localparam logic [ISI_W-1:0]  IVL_MAX  = '1;

  typedef enum logic [1:0] {IDLE, MEASURE, HOLD} state_e;

  state_e            state_q, state_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [RATE_W-1:0] cnt_q, cnt_d;
  logic [ISI_W-1:0]  ivl_q, ivl_d;
  logic [ISI_W-1:0]  ist_q, ist_d;
  logic              seen_q, seen_d;
  logic              ovf_q, ovf_d;
  logic              prev_q;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [ISI_W-1:0]  isi_q, isi_d;
  logic              ovfo_q, ovfo_d;
  logic              spike_ev;
  logic              clr;

  assign spike_ev = spike_in & ~prev_q;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    ivl_d   = ivl_q;
    ist_d   = ist_q;
    seen_d  = seen_q;
    ovf_d   = ovf_q;
    rate_d  = rate_q;
    isi_d   = isi_q;
    ovfo_d  = ovfo_q;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = MEASURE;
          clr     = 1'b1;
        end
      end
      MEASURE: begin
        if (!en) begin
          state_d = IDLE;
        end else begin
          win_d = win_q + WIN_W'(1);
          if (spike_ev) begin
            if (cnt_q == CNT_MAX) ovf_d = 1'b1;
            else                  cnt_d = cnt_q + RATE_W'(1);
            if (seen_q) ist_d = ivl_q;
            ivl_d  = ISI_W'(1);
            seen_d = 1'b1;
          end else begin
            if (ivl_q == IVL_MAX) ovf_d = 1'b1;
            else                  ivl_d = ivl_q + ISI_W'(1);
          end
          // Latch uses the _d values so an event in the last window cycle is included.
          if (win_q == WIN_LAST) begin
            state_d = HOLD;
            rate_d  = cnt_d;
            isi_d   = ist_d;
            ovfo_d  = ovf_d;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = en ? MEASURE : IDLE;
          clr     = en;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      win_d  = '0;
      cnt_d  = '0;
      ivl_d  = '0;
      ist_d  = '0;
      seen_d = 1'b0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      cnt_q   <= '0;
      ivl_q   <= '0;
      ist_q   <= '0;
      seen_q  <= 1'b0;
      ovf_q   <= 1'b0;
      prev_q  <= 1'b0;
      rate_q  <= '0;
      isi_q   <= '0;
      ovfo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      ivl_q   <= ivl_d;
      ist_q   <= ist_d;
      seen_q  <= seen_d;
      ovf_q   <= ovf_d;
      prev_q  <= spike_in;
      rate_q  <= rate_d;
      isi_q   <= isi_d;
      ovfo_q  <= ovfo_d;
    end
  end

  assign rate_out  = rate_q;
  assign isi_out   = isi_q;
  assign overflow  = ovfo_q;
  assign out_valid = (state_q == HOLD);

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: a WINDOW=100 instance for the table and corner sequences,
// a WINDOW=1000 instance for count saturation.
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, spk, rdy;
  logic [7:0] rate;
  logic [15:0] isi;
  logic       ovf, ov;
  logic       en1, spk1, rdy1;
  logic [7:0] rate1;
  logic [15:0] isi1;
  logic       ovf1, ov1;

  always #5 clk = ~clk;

  spike_rate_decoder #(.WINDOW(100), .RATE_W(8), .ISI_W(16)) u100 (
    .clk(clk), .rst(rst), .en(en), .spike_in(spk), .rate_out(rate), .isi_out(isi),
    .overflow(ovf), .out_valid(ov), .out_ready(rdy));

  spike_rate_decoder #(.WINDOW(1000), .RATE_W(8), .ISI_W(16)) u1k (
    .clk(clk), .rst(rst), .en(en1), .spike_in(spk1), .rate_out(rate1), .isi_out(isi1),
    .overflow(ovf1), .out_valid(ov1), .out_ready(rdy1));

  typedef struct {
    string nm;
    int    p, s, wd;
    int    rate, isi;
    bit    ovf;
  } vec_t;

  typedef struct {
    string nm;
    int    rate, isi;
    bit    ovf;
  } exp_t;

  vec_t tbl[6];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Spike high at window cycle w when w>=s and (w-s) mod p < wd; inv flips the level.
  task automatic drive_window(input string nm, input int p, input int s, input int wd, input bit inv);
    for (int w = 0; w < 100; w++) begin
      spk = inv ^ ((w >= s) && (((w - s) % p) < wd));
      if (w == 99) chk({nm, " valid early"}, int'(ov), 0);
      step();
    end
    spk = 1'b0;
    chk({nm, " valid at 101"}, int'(ov), 1);
  endtask

  task automatic wait_result();
    exp_t e;
    int   t;
    t = 0;
    while (!ov && t < 50) begin
      step();
      t++;
    end
    if (!ov) begin
      chk("result timeout", 0, 1);
    end else if (sb.size() == 0) begin
      chk("unexpected result", 0, 1);
    end else begin
      e = sb.pop_front();
      chk({e.nm, " rate"}, int'(rate), e.rate);
      chk({e.nm, " isi"},  int'(isi),  e.isi);
      chk({e.nm, " ovf"},  int'(ovf),  int'(e.ovf));
    end
  endtask

  task automatic ack_to_idle();
    rdy = 1'b1;
    en  = 1'b0;
    step();
    rdy = 1'b0;
    chk("valid drop after ack", int'(ov), 0);
  endtask

  task automatic run_vec(input vec_t v);
    sb.push_back('{v.nm, v.rate, v.isi, v.ovf});
    en  = 1'b1;
    spk = 1'b0;
    step();
    drive_window(v.nm, v.p, v.s, v.wd, 1'b0);
    wait_result();
  endtask

  initial begin
    bit   stuck;
    vec_t v;
    tbl[0] = '{"periodic10", 10,   5,   1, 10, 10, 1'b0};
    tbl[1] = '{"level50",    1000, 10, 50, 1,  0,  1'b0};
    tbl[2] = '{"none",       1000, 200, 1, 0,  0,  1'b0};
    tbl[3] = '{"pair3_80",   77,   3,   1, 2,  77, 1'b0};
    tbl[4] = '{"wide3p7",    7,    0,   3, 15, 7,  1'b0};
    tbl[5] = '{"lastcycle",  99,   0,   1, 2,  99, 1'b0};

    // Reset held with spike and enable high.
    rst = 1'b1; en = 1'b1; spk = 1'b1; rdy = 1'b0;
    en1 = 1'b0; spk1 = 1'b0; rdy1 = 1'b0;
    step(); step();
    chk("reset rate",  int'(rate), 0);
    chk("reset isi",   int'(isi),  0);
    chk("reset ovf",   int'(ovf),  0);
    chk("reset valid", int'(ov),   0);
    rst = 1'b0;
    // Still-high spike must not count; only the re-rise at window cycle 20 does.
    sb.push_back('{"post-reset level", 1, 0, 1'b0});
    step();
    drive_window("post-reset", 1000, 10, 10, 1'b1);
    wait_result();
    ack_to_idle();

    foreach (tbl[i]) begin
      run_vec(tbl[i]);
      ack_to_idle();
    end

    // Backpressure: HOLD with spikes toggling must keep outputs frozen.
    v = tbl[0];
    v.nm = "bp first";
    run_vec(v);
    stuck = 1'b0;
    for (int c = 0; c < 20; c++) begin
      spk = ~spk;
      step();
      if (rate != 8'd10 || isi != 16'd10 || ovf || !ov) stuck = 1'b1;
    end
    chk("bp hold stable", int'(stuck), 0);
    spk = 1'b0; en = 1'b1; rdy = 1'b1;
    step();
    rdy = 1'b0;
    chk("bp valid drop", int'(ov), 0);
    sb.push_back('{"bp second", 4, 25, 1'b0});
    drive_window("bp second", 25, 1, 1, 1'b0);
    wait_result();
    ack_to_idle();

    // Abort at window cycle 40: no result, outputs retained.
    en = 1'b1; spk = 1'b0;
    step();
    for (int w = 0; w < 40; w++) begin
      spk = (w % 10) == 5;
      step();
    end
    en = 1'b0; spk = 1'b0;
    stuck = 1'b0;
    for (int c = 0; c < 120; c++) begin
      step();
      if (ov) stuck = 1'b1;
    end
    chk("abort no valid", int'(stuck), 0);
    chk("abort rate kept", int'(rate), 4);
    chk("abort isi kept",  int'(isi),  25);
    v = tbl[3];
    v.nm = "after abort";
    run_vec(v);

    // Reset while a result is pending discards it.
    #2 rst = 1'b1;
    #1;
    chk("hold reset valid", int'(ov),   0);
    chk("hold reset rate",  int'(rate), 0);
    chk("hold reset isi",   int'(isi),  0);
    step();
    rst = 1'b0; en = 1'b0;
    step(); step();
    chk("post hold reset idle", int'(ov), 0);

    // Count saturation on the 1000-cycle instance.
    en1 = 1'b1; spk1 = 1'b0;
    step();
    for (int w = 0; w < 1000; w++) begin
      spk1 = (w % 2) == 0;
      step();
    end
    spk1 = 1'b0;
    for (int t = 0; t < 5 && !ov1; t++) step();
    chk("sat valid", int'(ov1),   1);
    chk("sat rate",  int'(rate1), 255);
    chk("sat ovf",   int'(ovf1),  1);
    chk("sat isi",   int'(isi1),  2);
    en1 = 1'b0; rdy1 = 1'b1;
    step();
    rdy1 = 1'b0;
    chk("sat ack", int'(ov1), 0);
    chk("scoreboard drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
